// File: rtl/seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// seg_display_arbiter
//   Shares one 4-digit seven-segment display between NREQ message sources.
//   Normal requesters are served round-robin. Each normal grant holds the
//   display for at least DWELL cycles while the owner keeps requesting. Any
//   requester that also raises its urgent bit preempts the rotation at once.
//   The lowest urgent index wins, but a held urgent owner is never displaced
//   by another urgent source.
//
// Ports
//   clk           system clock, all state changes on posedge
//   rst           asynchronous active-low reset (0 = reset)
//   req           [NREQ]     level request per source
//   urgent        [NREQ]     urgent qualifier, effective only while req is set
//   nums_in       [16*NREQ]  source i display word at nums_in[16*i +: 16]
//   nums_out      [16]       registered word for the display driver
//   grant         [NREQ]     registered one-hot owner, all zero when idle
//   grant_valid              |grant
//   switch_pulse             one-cycle pulse when grant takes a new nonzero value
// -----------------------------------------------------------------------------
module seg_display_arbiter #(
  parameter int          NREQ      = 4,
  parameter int          DWELL     = 50_000_000,
  parameter int          CW        = 26,
  parameter logic [15:0] IDLE_NUMS = 16'hBBBB
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      urgent,
  input  logic [16*NREQ-1:0]   nums_in,
  output logic [15:0]          nums_out,
  output logic [NREQ-1:0]      grant,
  output logic                 grant_valid,
  output logic                 switch_pulse
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

  typedef logic [IW-1:0] idx_t;
  typedef enum logic [1:0] {S_IDLE, S_RR_HOLD, S_URGENT} state_t;

  // Lowest set index of v. Callers only use the result when v is nonzero.
  function automatic idx_t lowest_idx(input logic [NREQ-1:0] v);
    idx_t r;
    r = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (v[idx_t'(i)]) r = idx_t'(i);
    end
    return r;
  endfunction

  // First set index strictly after p, searched circularly. If only p is set,
  // the search wraps back to p. Descending loop so the smallest offset wins.
  function automatic idx_t next_after(input logic [NREQ-1:0] v, input idx_t p);
    idx_t r;
    int   j;
    r = p;
    for (int i = NREQ; i >= 1; i--) begin
      j = int'(p) + i;
      if (j >= NREQ) j = j - NREQ;
      if (v[idx_t'(j)]) r = idx_t'(j);
    end
    return r;
  endfunction

  // State
  state_t          r_state;
  idx_t            r_owner;
  idx_t            r_ptr;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_grant;
  logic [15:0]     r_nums;
  logic            r_switch;

  // Next-state values
  state_t          w_state_nxt;
  idx_t            w_owner_nxt;
  idx_t            w_ptr_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [NREQ-1:0] w_grant_nxt;
  logic            w_valid_nxt;
  logic [NREQ-1:0] w_u;
  logic [NREQ-1:0] w_owner_mask;
  logic [15:0]     w_words [NREQ];

  assign w_u          = req & urgent;
  assign w_owner_mask = NREQ'(1) << r_owner;

  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign w_words[g] = nums_in[16*g +: 16];
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = '0;

    unique case (r_state)
      S_IDLE: begin
        if (|w_u) begin
          w_state_nxt = S_URGENT;
          w_owner_nxt = lowest_idx(w_u);
        end else if (|req) begin
          w_state_nxt = S_RR_HOLD;
          w_owner_nxt = next_after(req, r_ptr);
        end
      end

      S_RR_HOLD: begin
        if (|w_u) begin
          // Urgent wins over both owner drop and dwell expiry.
          w_state_nxt = S_URGENT;
          w_owner_nxt = lowest_idx(w_u);
        end else if (!req[r_owner]) begin
          // Owner gave up: move on immediately, no dwell wait.
          w_ptr_nxt = r_owner;
          if (|req) begin
            w_owner_nxt = next_after(req, r_owner);
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (r_cnt == DWELL_LAST) begin
          // Dwell served. Rotate only if someone else is waiting; otherwise
          // the owner simply starts a fresh dwell period.
          if ((req & ~w_owner_mask) != '0) begin
            w_ptr_nxt   = r_owner;
            w_owner_nxt = next_after(req, r_owner);
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_URGENT: begin
        if (w_u[r_owner]) begin
          w_owner_nxt = r_owner;
        end else if (|w_u) begin
          w_owner_nxt = lowest_idx(w_u);
        end else begin
          // Urgent traffic over: resume the rotation after the last owner.
          w_ptr_nxt = r_owner;
          if (|req) begin
            w_state_nxt = S_RR_HOLD;
            w_owner_nxt = next_after(req, r_owner);
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_valid_nxt = (w_state_nxt != S_IDLE);
    w_grant_nxt = w_valid_nxt ? (NREQ'(1) << w_owner_nxt) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_owner  <= '0;
      r_ptr    <= idx_t'(NREQ - 1);
      r_cnt    <= '0;
      r_grant  <= '0;
      r_nums   <= IDLE_NUMS;
      r_switch <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_ptr    <= w_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_grant  <= w_grant_nxt;
      r_nums   <= w_valid_nxt ? w_words[w_owner_nxt] : IDLE_NUMS;
      r_switch <= w_valid_nxt && (w_grant_nxt != r_grant);
    end
  end

  assign nums_out     = r_nums;
  assign grant        = r_grant;
  assign grant_valid  = |r_grant;
  assign switch_pulse = r_switch;

endmodule
